mem_loader: RTL and testbench

//   Write-side initiator for the 256x8 program/data memory. It accepts a byte stream over a

---
 rtl/mem_loader.sv | 160 ++++++++++++++++
 tb/tb_mem_loader.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_loader.sv
// mem_loader: write-side initiator for a 2**ADDR_W x DATA_W program/data memory.
// Accepts a byte stream over valid/ready and writes it to consecutive addresses
// starting at a latched base address (wrapping at the top of memory). Optionally
// reads the region back and compares an additive checksum. cpu_hold keeps the
// processor core off the memory while a session runs.
//
// Ports:
//   clk        in   rising-edge clock
//   rst_n      in   synchronous active-low reset
//   start      in   session request, sampled only in IDLE
//   base_addr  in   first write address, latched on start
//   len        in   byte count 0..2**ADDR_W, latched on start
//   s_valid    in   stream byte valid
//   s_data     in   stream byte
//   s_ready    out  loader accepts a byte this cycle (LOAD)
//   mem_addr   out  memory address
//   mem_din    out  memory write data
//   mem_we     out  memory write enable (commits on the same clk edge)
//   mem_dout   in   memory read data (combinational read)
//   busy       out  high in LOAD and VERIFY
//   cpu_hold   out  equals busy
//   done       out  one-cycle pulse at end of session
//   error      out  read-back checksum mismatch, sticky until next start/reset
//   checksum   out  sum of loaded bytes mod 2**DATA_W, valid from done onward
module mem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter bit VERIFY = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   len,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_dout,
  output logic              busy,
  output logic              cpu_hold,
  output logic              done,
  output logic              error,
  output logic [DATA_W-1:0] checksum
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0] wsum_q, wsum_d;
  logic [DATA_W-1:0] rsum_q, rsum_d;
  logic [DATA_W-1:0] chk_q, chk_d;
  logic              err_q, err_d;
  logic              last_c;

  // cnt is one bit wider than the address so len = 2**ADDR_W still has a
  // representable final index (len-1).
  assign last_c   = (cnt_q == (len_q - CNT_ONE));

  assign s_ready  = (state_q == S_LOAD);
  // Reset gates the write enable combinationally so a reset cycle never writes.
  assign mem_we   = (state_q == S_LOAD) && s_valid && rst_n;
  assign mem_addr = (state_q == S_IDLE) ? base_q : (base_q + cnt_q[ADDR_W-1:0]);
  assign mem_din  = (state_q == S_LOAD) ? s_data : '0;
  assign busy     = (state_q == S_LOAD) || (state_q == S_VERIFY);
  assign cpu_hold = busy;
  assign done     = (state_q == S_DONE);
  assign error    = err_q;
  assign checksum = chk_q;

  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    wsum_d  = wsum_q;
    rsum_d  = rsum_q;
    chk_d   = chk_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          base_d = base_addr;
          len_d  = len;
          cnt_d  = '0;
          wsum_d = '0;
          rsum_d = '0;
          chk_d  = '0;
          err_d  = 1'b0;
          // An empty session skips straight to DONE with a zero checksum.
          state_d = (len == '0) ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (s_valid) begin
          wsum_d = wsum_q + s_data;
          cnt_d  = cnt_q + CNT_ONE;
          if (last_c) begin
            cnt_d  = '0;
            rsum_d = '0;
            if (VERIFY) begin
              state_d = S_VERIFY;
            end else begin
              state_d = S_DONE;
              chk_d   = wsum_q + s_data;
            end
          end
        end
      end
      S_VERIFY: begin
        rsum_d = rsum_q + mem_dout;
        cnt_d  = cnt_q + CNT_ONE;
        if (last_c) begin
          state_d = S_DONE;
          chk_d   = wsum_q;
          if (rsum_d != wsum_q) err_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      wsum_q  <= '0;
      rsum_q  <= '0;
      chk_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wsum_q  <= wsum_d;
      rsum_q  <= rsum_d;
      chk_q   <= chk_d;
      err_q   <= err_d;
    end
  end

  // Session parameters are plain data latches; they are only meaningful
  // after a start and need no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    len_q  <= len_d;
  end

endmodule

// File: tb/tb_mem_loader.sv
`timescale 1ns/1ps
module tb_mem_loader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [7:0] base_addr;
  logic [8:0] len;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] mem_addr;
  logic [7:0] mem_din;
  logic       mem_we;
  logic [7:0] mem_dout;
  logic       busy;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [7:0] checksum;

  always #5 clk = ~clk;

  mem_loader #(.ADDR_W(8), .DATA_W(8), .VERIFY(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .len(len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we), .mem_dout(mem_dout),
    .busy(busy), .cpu_hold(cpu_hold), .done(done), .error(error), .checksum(checksum)
  );

  typedef struct { logic [7:0] addr; logic [7:0] data; } wr_t;
  typedef struct { logic [7:0] sum; logic err; int cyc; } dn_t;

  logic [7:0] mem     [256];
  logic [7:0] ref_mem [256];
  bit         corrupt = 1'b0;
  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  wr_t        wq[$];
  dn_t        dq[$];
  logic [7:0] stim[$];
  int         gaps[$];

  // Memory model: synchronous write, combinational read. When corrupt is set,
  // address 0x01 reads back as zero during the read-back pass (busy, not ready).
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (mem_we) mem[mem_addr] <= mem_din;
  end
  assign mem_dout = (corrupt && busy && !s_ready && mem_addr == 8'h01) ? 8'h00 : mem[mem_addr];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fail_now(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: event did not match expectation", nm);
  endtask

  // Monitor: pops expected writes and expected session results as the DUT presents them.
  always @(negedge clk) begin
    wr_t w;
    dn_t d;
    if (!rst_n && mem_we) fail_now("write_during_reset");
    if (cpu_hold != busy) fail_now("cpu_hold_vs_busy");
    if (mem_we) begin
      if (wq.size() == 0) fail_now("unexpected_write");
      else begin
        w = wq.pop_front();
        chk("wr_addr", mem_addr, w.addr);
        chk("wr_data", mem_din, w.data);
      end
    end
    if (done) begin
      if (dq.size() == 0) fail_now("unexpected_done");
      else begin
        d = dq.pop_front();
        chk("checksum", checksum, d.sum);
        chk("error", error, d.err);
        chk("done_cycle", cyc, d.cyc);
      end
    end
  end

  // Runs one session using the bytes in stim. gap_mode: 0 none, 1 alternate, 2 random.
  task automatic run_session(input logic [7:0] base, input int gap_mode, input bit corr);
    int n, g, ok;
    logic [7:0] sum, a;
    logic experr;
    dn_t d;
    n = stim.size();
    g = 0;
    sum = 8'h00;
    experr = 1'b0;
    gaps.delete();
    for (int i = 0; i < n; i++) begin
      gaps.push_back(gap_mode == 0 ? 0 : (gap_mode == 1 ? (i > 0 ? 1 : 0) : int'($urandom_range(0, 2))));
      g += gaps[i];
      a = base + i[7:0];
      sum = sum + stim[i];
      ref_mem[a] = stim[i];
      wq.push_back('{a, stim[i]});
      if (corr && a == 8'h01 && stim[i] != 8'h00) experr = 1'b1;
    end
    corrupt = corr;
    base_addr = base;
    len = n[8:0];
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    d.sum = sum;
    d.err = experr;
    d.cyc = cyc + 2 * n + g;
    dq.push_back(d);
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < gaps[i]; k++) begin
        s_valid = 1'b0;
        s_data = 8'($urandom);
        @(posedge clk); #1;
      end
      chk("s_ready", s_ready, 1);
      s_valid = 1'b1;
      s_data = stim[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    ok = 0;
    for (int k = 0; k < n + 8; k++) begin
      if (n == 0) chk("busy_len0", busy, 0);
      if (done) begin
        ok = 1;
        break;
      end
      @(posedge clk); #1;
    end
    if (ok == 0) fail_now("done_timeout");
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      chk("done_after", done, 0);
      chk("busy_after", busy, 0);
      chk("error_hold", error, experr);
      chk("checksum_hold", checksum, sum);
    end
    for (int i = 0; i < n; i++) begin
      a = base + i[7:0];
      chk("mem_content", mem[a], ref_mem[a]);
    end
    corrupt = 1'b0;
    stim.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    logic [7:0] a;
    int n;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00;
      ref_mem[i] = 8'h00;
    end
    rst_n = 1'b0;
    start = 1'b0;
    base_addr = 8'h00;
    len = 9'd0;
    s_valid = 1'b0;
    s_data = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_done", done, 0);
    chk("rst_error", error, 0);
    chk("rst_checksum", checksum, 0);
    chk("rst_mem_we", mem_we, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic load, continuous stream.
    stim = '{8'h22, 8'h27, 8'h61, 8'h30};
    run_session(8'h00, 0, 1'b0);
    // Same stream with gaps on alternate cycles.
    stim = '{8'h22, 8'h27, 8'h61, 8'h30};
    run_session(8'h00, 1, 1'b0);
    // Wrap past the top of memory.
    stim = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_session(8'hFE, 0, 1'b0);
    // Read-back corruption at address 0x01.
    stim = '{8'h22, 8'h27, 8'h61, 8'h30};
    run_session(8'h00, 0, 1'b1);
    // Empty session.
    run_session(8'h40, 0, 1'b0);

    // Reset after two of four bytes.
    b = 8'($urandom);
    for (int i = 0; i < 4; i++) stim.push_back(8'($urandom_range(1, 255)));
    for (int i = 0; i < 2; i++) begin
      a = b + i[7:0];
      ref_mem[a] = stim[i];
      wq.push_back('{a, stim[i]});
    end
    base_addr = b;
    len = 9'd4;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_valid = 1'b1;
      s_data = stim[i];
      @(posedge clk); #1;
    end
    s_valid = 1'b1;
    s_data = stim[2];
    rst_n = 1'b0;
    @(negedge clk);
    chk("we_in_reset", mem_we, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    s_valid = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_s_ready", s_ready, 0);
    chk("abort_done", done, 0);
    chk("abort_cpu_hold", cpu_hold, 0);
    chk("abort_checksum", checksum, 0);
    for (int i = 0; i < 3; i++) begin
      a = b + i[7:0];
      chk("abort_mem", mem[a], ref_mem[a]);
    end
    stim.delete();
    @(posedge clk); #1;
    stim.push_back(8'($urandom));
    run_session(8'($urandom), 0, 1'b0);

    // Randomized sessions.
    for (int s = 0; s < 8; s++) begin
      n = $urandom_range(1, 24);
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
      run_session(8'($urandom), 2, ($urandom_range(0, 3) == 0));
    end

    // Whole-memory fill from a random base.
    for (int i = 0; i < 256; i++) stim.push_back(8'($urandom));
    run_session(8'($urandom), 0, 1'b0);

    if (wq.size() != 0) fail_now("writes_missing");
    if (dq.size() != 0) fail_now("done_missing");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
